psmac_dot_seq: RTL and testbench

- Sequencer that drives the OAFU precision-scalable MAC in signed 8-bit mode and accumulates a dot product of LEN operand pairs.
- Accepts 8-bit signed operand pairs over a valid/ready stream.
- Packs each pair into the OAFU 32-bit a/b lane format and holds the fixed 8-bit shift/mode configuration.
- Waits the OAFU latency, captures y, accumulates it, and returns the sum over a valid/ready result channel.

---
 rtl/psmac_pkg.sv | 36 +++
 rtl/psmac_pack8.sv | 15 +
 rtl/psmac_dot_seq.sv | 142 ++++++++++++++
 tb/tb_psmac_dot_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psmac_pkg.sv
// psmac_pkg: shared types, 8-bit mode configuration and lane packing helpers
// for sequencers that drive the OAFU precision-scalable MAC.
package psmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Shift codes and mode bits that put the OAFU into signed 8x8 operation.
  localparam logic [3:0] SX8_1 = 4'h0;
  localparam logic [3:0] SX8_2 = 4'hA;
  localparam logic [3:0] SX8_3 = 4'h0;
  localparam logic [3:0] SX8_4 = 4'hA;
  localparam logic [3:0] SY8_1 = 4'h0;
  localparam logic [3:0] SY8_2 = 4'h0;
  localparam logic [3:0] SY8_3 = 4'hC;
  localparam logic [3:0] SY8_4 = 4'hC;
  localparam logic       MODE8_1 = 1'b1;
  localparam logic       MODE8_2 = 1'b1;

  // A is split into nibbles; each nibble is duplicated across the lanes.
  function automatic logic [31:0] pack_a8(input logic [7:0] a);
    return {a[7:4], a[7:4], a[3:0], a[3:0], a[7:4], a[7:4], a[3:0], a[3:0]};
  endfunction

  // B is split into 2-bit crumbs; each crumb appears twice in succession.
  function automatic logic [31:0] pack_b8(input logic [7:0] b);
    return {b[7:6], b[7:6], b[5:4], b[5:4], b[7:6], b[7:6], b[5:4], b[5:4],
            b[3:2], b[3:2], b[1:0], b[1:0], b[3:2], b[3:2], b[1:0], b[1:0]};
  endfunction

endpackage

// File: rtl/psmac_pack8.sv
// psmac_pack8: combinational packer from an 8-bit operand pair to the OAFU
// 32-bit a/b lane format for signed 8-bit mode.
module psmac_pack8
  import psmac_pkg::*;
(
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [31:0] o_a,
  output logic [31:0] o_b
);

  assign o_a = pack_a8(i_a);
  assign o_b = pack_b8(i_b);

endmodule

// File: rtl/psmac_dot_seq.sv
// psmac_dot_seq: feeds signed 8-bit operand pairs to the OAFU one at a time,
// waits out its latency, and accumulates the products into a dot product.
module psmac_dot_seq
  import psmac_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_len,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_a,
  input  logic [7:0]       i_in_b,
  output logic [31:0]      o_oafu_a,
  output logic [31:0]      o_oafu_b,
  output logic [3:0]       o_sx1,
  output logic [3:0]       o_sx2,
  output logic [3:0]       o_sx3,
  output logic [3:0]       o_sx4,
  output logic [3:0]       o_sy1,
  output logic [3:0]       o_sy2,
  output logic [3:0]       o_sy3,
  output logic [3:0]       o_sy4,
  output logic             o_mode1,
  output logic             o_mode2,
  input  logic [15:0]      i_oafu_y,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_out_acc,
  output logic             o_busy
);

  localparam int               CNT_W   = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  state_t             r_state;
  logic [7:0]         r_remaining;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [31:0]        r_oafu_a;
  logic [31:0]        r_oafu_b;
  logic [31:0]        w_pack_a;
  logic [31:0]        w_pack_b;
  logic [ACC_W-1:0]   w_y_ext;

  psmac_pack8 u_pack8 (
    .i_a (i_in_a),
    .i_b (i_in_b),
    .o_a (w_pack_a),
    .o_b (w_pack_b)
  );

  assign w_y_ext = ACC_W'($signed(i_oafu_y));

  // Configuration is hard-wired so it is valid even while in reset.
  assign o_sx1   = SX8_1;
  assign o_sx2   = SX8_2;
  assign o_sx3   = SX8_3;
  assign o_sx4   = SX8_4;
  assign o_sy1   = SY8_1;
  assign o_sy2   = SY8_2;
  assign o_sy3   = SY8_3;
  assign o_sy4   = SY8_4;
  assign o_mode1 = MODE8_1;
  assign o_mode2 = MODE8_2;

  assign o_oafu_a    = r_oafu_a;
  assign o_oafu_b    = r_oafu_b;
  assign o_in_ready  = (r_state == ST_LOAD);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_out_acc   = r_acc;
  assign o_busy      = (r_state != ST_IDLE);

  // Sequencer: one pair per pass through LOAD -> WAIT (LAT cycles) -> ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= 8'd0;
      r_wait_cnt  <= '0;
      r_acc       <= '0;
      r_oafu_a    <= 32'd0;
      r_oafu_b    <= 32'd0;
    end else if (i_clear) begin
      r_state     <= ST_IDLE;
      r_remaining <= 8'd0;
      r_wait_cnt  <= '0;
      r_acc       <= '0;
      r_oafu_a    <= 32'd0;
      r_oafu_b    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc <= '0;
            if (i_len != 8'd0) begin
              r_remaining <= i_len;
              r_state     <= ST_LOAD;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            r_oafu_a   <= w_pack_a;
            r_oafu_b   <= w_pack_b;
            r_wait_cnt <= LAT_CNT;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          if (r_wait_cnt == CNT_W'(1)) begin
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_acc       <= r_acc + w_y_ext;
          r_remaining <= r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psmac_dot_seq.sv
// tb_psmac_dot_seq: randomized bench for the dot-product sequencer with a
// behavioural OAFU and a plain-arithmetic dot-product reference.
module tb_psmac_dot_seq;

  localparam int LAT   = 2;
  localparam int ACC_W = 24;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [7:0]              len = 8'd0;
  logic                    clear = 1'b0;
  logic                    inValid = 1'b0;
  logic                    inReady;
  logic [7:0]              inA = 8'd0;
  logic [7:0]              inB = 8'd0;
  logic [31:0]             oafuA;
  logic [31:0]             oafuB;
  logic [3:0]              sx1, sx2, sx3, sx4, sy1, sy2, sy3, sy4;
  logic                    mode1, mode2;
  logic [15:0]             oafuY;
  logic                    outValid;
  logic                    outReady = 1'b0;
  logic signed [ACC_W-1:0] outAcc;
  logic                    busy;

  int checkCount = 0;
  int errorCount = 0;
  int readyBad   = 0;
  int stableBad  = 0;
  logic [7:0] pa[$];
  logic [7:0] pb[$];

  always #5 clk = ~clk;

  psmac_dot_seq #(.LAT(LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_len(len), .i_clear(clear),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_in_a(inA), .i_in_b(inB),
    .o_oafu_a(oafuA), .o_oafu_b(oafuB),
    .o_sx1(sx1), .o_sx2(sx2), .o_sx3(sx3), .o_sx4(sx4),
    .o_sy1(sy1), .o_sy2(sy2), .o_sy3(sy3), .o_sy4(sy4),
    .o_mode1(mode1), .o_mode2(mode2), .i_oafu_y(oafuY),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_acc(outAcc), .o_busy(busy)
  );

  // Behavioural OAFU: recovers the operands from the lanes, multiplies, and
  // presents the product LAT cycles after the operand registers change.
  function automatic logic [15:0] oafuProduct(input logic [31:0] a, input logic [31:0] b);
    logic signed [7:0]  av;
    logic signed [7:0]  bv;
    logic signed [15:0] p;
    av = {a[31:28], a[23:20]};
    bv = {b[31:30], b[27:26], b[15:14], b[11:10]};
    p  = av * bv;
    return p;
  endfunction

  logic [15:0] yPipe [LAT];

  always @(posedge clk) begin
    yPipe[0] <= oafuProduct(oafuA, oafuB);
    for (int i = 1; i < LAT; i++) yPipe[i] <= yPipe[i-1];
  end

  assign oafuY = yPipe[LAT-1];

  function automatic logic [31:0] refPackA(input logic [7:0] a);
    return {{2{a[7:4]}}, {2{a[3:0]}}, {2{a[7:4]}}, {2{a[3:0]}}};
  endfunction

  function automatic logic [31:0] refPackB(input logic [7:0] b);
    return {{2{b[7:6]}}, {2{b[5:4]}}, {2{b[7:6]}}, {2{b[5:4]}},
            {2{b[3:2]}}, {2{b[1:0]}}, {2{b[3:2]}}, {2{b[1:0]}}};
  endfunction

  function automatic int refDot(input int n);
    int sum = 0;
    for (int k = 0; k < n; k++) sum += int'($signed(pa[k])) * int'($signed(pb[k]));
    return sum;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Offers one pair and returns at the first falling edge after the handshake.
  task automatic handshakePair(input logic [7:0] a, input logic [7:0] b, output logic ok);
    int guard = 0;
    ok = 1'b1;
    inValid = 1'b1; inA = a; inB = b;
    while (!inReady && guard < 100) begin @(negedge clk); guard++; end
    if (!inReady) begin
      checkOutput("inReadyTimeout", 0, 1);
      inValid = 1'b0; ok = 1'b0;
      return;
    end
    @(negedge clk);
    inValid = 1'b0; inA = 8'($urandom); inB = 8'($urandom);
  endtask

  // Runs one dot product over the first n queued pairs and checks the result.
  task automatic applyStimulus(input int n, input int gapMax, input int holdCycles,
                               input int expected, output int latency);
    logic ok;
    int   guard;
    logic signed [ACC_W-1:0] accHeld;
    latency = 0;
    @(negedge clk); start = 1'b1; len = 8'(n);
    @(negedge clk); start = 1'b0; len = 8'($urandom);
    latency = 1;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(gapMax, 0)) @(negedge clk);
      handshakePair(pa[k], pb[k], ok);
      if (!ok) return;
      checkOutput("packA", oafuA, refPackA(pa[k]));
      checkOutput("packB", oafuB, refPackB(pb[k]));
      latency = 1;
      for (int c = 0; c < LAT + 1; c++) begin
        if (inReady) readyBad++;
        if (oafuA !== refPackA(pa[k]) || oafuB !== refPackB(pb[k])) stableBad++;
        if (c < LAT) begin @(negedge clk); latency++; end
      end
    end
    guard = 0;
    while (!outValid && guard < 2000) begin @(negedge clk); latency++; guard++; end
    if (!outValid) begin
      checkOutput("outValidTimeout", 0, 1);
      return;
    end
    accHeld = outAcc;
    for (int h = 0; h < holdCycles; h++) begin
      start = 1'($urandom_range(1, 0)); len = 8'($urandom);
      @(negedge clk);
      if (!outValid || outAcc !== accHeld || !busy || inReady) stableBad++;
    end
    start = 1'b0;
    checkOutput("outAcc", int'(outAcc), expected);
    outReady = 1'b1;
    @(negedge clk); outReady = 1'b0;
    checkOutput("outValidDrop", int'(outValid), 0);
    checkOutput("idleBusy", int'(busy), 0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   n;
    logic ok;

    // Reset and configuration constants (checked while reset is held).
    repeat (2) @(negedge clk);
    checkOutput("cfgShift", {sx1, sx2, sx3, sx4, sy1, sy2, sy3, sy4}, 32'h0A0A00CC);
    checkOutput("cfgMode", int'({mode1, mode2}), 3);
    checkOutput("rstOafuA", oafuA, 0);
    checkOutput("rstOafuB", oafuB, 0);
    checkOutput("rstFlags", int'({inReady, outValid, busy}), 0);
    checkOutput("rstAcc", int'(outAcc), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Packing example.
    pa = {8'hA5}; pb = {8'hA5};
    @(negedge clk); start = 1'b1; len = 8'd1;
    @(negedge clk); start = 1'b0;
    handshakePair(pa[0], pb[0], ok);
    checkOutput("packA5a", oafuA, 32'hAA55AA55);
    checkOutput("packA5b", oafuB, 32'hAAAA5555);
    repeat (LAT + 1) @(negedge clk);
    checkOutput("packA5acc", int'(outAcc), 8281);
    outReady = 1'b1; @(negedge clk); outReady = 1'b0;

    // Single product and its latency.
    pa = {8'h80}; pb = {8'h80};
    applyStimulus(1, 0, 0, 16384, lat);
    checkOutput("latency", lat, LAT + 2);

    // Dot product with input gaps and result backpressure.
    pa = {8'd3, -8'sd5, 8'd127}; pb = {8'd4, 8'd7, 8'h80};
    applyStimulus(3, 3, 10, -16279, lat);

    // Empty dot product.
    applyStimulus(0, 0, 0, 0, lat);
    checkOutput("len0Latency", lat, 1);

    // Longest dot product at the extreme product.
    pa.delete(); pb.delete();
    for (int k = 0; k < 255; k++) begin pa.push_back(8'h80); pb.push_back(8'h80); end
    applyStimulus(255, 0, 0, 4177920, lat);

    // Random dot products against the arithmetic reference.
    for (int r = 0; r < 6; r++) begin
      pa.delete(); pb.delete();
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) begin
        pa.push_back(8'($urandom)); pb.push_back(8'($urandom));
      end
      applyStimulus(n, 3, (r == 2) ? 4 : 0, refDot(n), lat);
    end

    // Abort during WAIT.
    @(negedge clk); start = 1'b1; len = 8'd2;
    @(negedge clk); start = 1'b0;
    handshakePair(8'd5, 8'd6, ok);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checkOutput("clearBusy", int'({busy, inReady, outValid}), 0);
    checkOutput("clearOafuA", oafuA, 0);
    checkOutput("clearOafuB", oafuB, 0);
    n = 0;
    repeat (8) begin @(negedge clk); if (outValid || busy) n++; end
    checkOutput("clearNoResult", n, 0);

    // Asynchronous reset while waiting for the second pair.
    @(negedge clk); start = 1'b1; len = 8'd2;
    @(negedge clk); start = 1'b0;
    handshakePair(8'd7, 8'd9, ok);
    repeat (LAT + 1) @(negedge clk);
    checkOutput("reloadReady", int'(inReady), 1);
    checkOutput("partialAcc", int'(outAcc), 63);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOafuA", oafuA, 0);
    checkOutput("midRstOafuB", oafuB, 0);
    checkOutput("midRstFlags", int'({inReady, outValid, busy}), 0);
    checkOutput("midRstAcc", int'(outAcc), 0);
    @(negedge clk); rst_n = 1'b1;
    pa = {8'd2}; pb = {8'd3};
    applyStimulus(1, 1, 0, 6, lat);

    checkOutput("inReadyOnlyInLoad", readyBad, 0);
    checkOutput("holdStable", stableBad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
